// File: rtl/noise_env_vca_if.sv
// Bus bundle for the noise envelope VCA: strobe, sample, and envelope
// controls in; enveloped sample, envelope level and status out.
interface noise_env_vca_if;
  logic               sample_en;
  logic signed [15:0] noise_in;
  logic        [3:0]  vel;
  logic               gate;
  logic        [7:0]  attack_rate;
  logic        [7:0]  release_rate;
  logic signed [15:0] audio_out;
  logic               out_valid;
  logic        [15:0] env_out;
  logic               busy;

  modport master (
    output sample_en, noise_in, vel, gate, attack_rate, release_rate,
    input  audio_out, out_valid, env_out, busy
  );
  modport slave (
    input  sample_en, noise_in, vel, gate, attack_rate, release_rate,
    output audio_out, out_valid, env_out, busy
  );
endinterface

// File: rtl/noise_env_vca.sv
// Linear AR(S) envelope applied to a noise source with velocity attenuation;
// two-stage pipeline: shift + envelope update, then multiply.
module noise_env_vca #(
  parameter int MAX_SHIFT = 8
) (
  input  logic            a_clk,
  input  logic            reset_n,
  noise_env_vca_if.slave  bus
);
  localparam int          STAGES = 2;
  localparam logic [3:0]  MAX_SH = 4'(MAX_SHIFT);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t              state, state_nxt;
  logic        [15:0]  env, env_nxt;
  logic                busy_r;
  logic        [15:0]  att_step, rel_step;
  logic        [16:0]  att_sum;
  logic        [3:0]   sh;
  logic [STAGES:1]     vld_pipe;
  logic signed [15:0]  atten;
  logic signed [15:0]  audio_r;
  logic signed [32:0]  prod;
  logic                unused_prod;

  always_comb begin
    att_step  = {bus.attack_rate, 8'h00};
    rel_step  = {bus.release_rate, 8'h00};
    att_sum   = {1'b0, env} + {1'b0, att_step};
    state_nxt = state;
    env_nxt   = env;
    if (bus.gate) begin
      // Retrigger from RELEASE continues from the current level.
      if (state == SUSTAIN) begin
        env_nxt = 16'hFFFF;
      end else if (bus.attack_rate == 8'h00 || att_sum >= 17'h0FFFF) begin
        env_nxt   = 16'hFFFF;
        state_nxt = SUSTAIN;
      end else begin
        env_nxt   = att_sum[15:0];
        state_nxt = ATTACK;
      end
    end else if (state != IDLE) begin
      if (bus.release_rate == 8'h00 || env <= rel_step) begin
        env_nxt   = 16'h0000;
        state_nxt = IDLE;
      end else begin
        env_nxt   = env - rel_step;
        state_nxt = RELEASE;
      end
    end else begin
      env_nxt = 16'h0000;
    end
  end

  assign sh = (bus.vel > MAX_SH) ? MAX_SH : bus.vel;

  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      env    <= 16'h0000;
      busy_r <= 1'b0;
    end else if (bus.sample_en) begin
      state  <= state_nxt;
      env    <= env_nxt;
      busy_r <= (state_nxt != IDLE);
    end
  end

  // env is the level captured on the stage-1 edge, so it pairs with atten.
  assign prod        = atten * $signed({1'b0, env});
  assign unused_prod = ^{prod[32], prod[15:0]};

  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      atten    <= '0;
      audio_r  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.sample_en};
      if (bus.sample_en) atten   <= bus.noise_in >>> sh;
      if (vld_pipe[1])   audio_r <= prod[31:16];
    end
  end

  assign bus.env_out   = env;
  assign bus.busy      = busy_r;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.audio_out = audio_r;
endmodule

// File: tb/tb_noise_env_vca.sv
// Scoreboard bench: driver models the envelope with integer arithmetic and
// queues expected samples; a negedge monitor checks each out_valid pulse.
module tb_noise_env_vca;
  logic a_clk = 1'b0;
  logic reset_n;
  noise_env_vca_if bus();

  noise_env_vca #(.MAX_SHIFT(8)) dut (.a_clk(a_clk), .reset_n(reset_n), .bus(bus));

  always #5 a_clk = ~a_clk;

  typedef struct { logic [15:0] audio; int cyc; } exp_t;
  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0;
  int   m_env = 0, m_ph = 0;      // phase: 0 idle, 1 attack, 2 sustain, 3 release
  logic [15:0] m_last = 16'h0;

  always @(posedge a_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Envelope rules evaluated directly from levels and rates.
  task automatic model_env(input logic g, input logic [7:0] ar, input logic [7:0] rr);
    int sa, sr;
    sa = int'(ar) * 256;
    sr = int'(rr) * 256;
    if (g) begin
      if (m_ph == 2) m_env = 65535;
      else if (ar == 0 || m_env + sa >= 65535) begin m_env = 65535; m_ph = 2; end
      else begin m_env = m_env + sa; m_ph = 1; end
    end else if (m_ph != 0) begin
      if (rr == 0 || m_env <= sr) begin m_env = 0; m_ph = 0; end
      else begin m_env = m_env - sr; m_ph = 3; end
    end
  endtask

  task automatic strobe(input logic [15:0] n, input logic [3:0] v, input logic g,
                        input logic [7:0] ar, input logic [7:0] rr);
    int sh, a;
    longint p;
    exp_t e;
    bus.sample_en = 1'b1; bus.noise_in = n; bus.vel = v; bus.gate = g;
    bus.attack_rate = ar; bus.release_rate = rr;
    model_env(g, ar, rr);
    sh = (v > 8) ? 8 : int'(v);
    a  = int'($signed(n)) >>> sh;
    p  = longint'(a) * longint'(m_env);
    p  = p >>> 16;
    e.audio = p[15:0];
    e.cyc   = cyc;
    q.push_back(e);
    @(posedge a_clk); #1;
    chk("env_out", {16'h0, bus.env_out}, m_env);
    chk("busy", {31'h0, bus.busy}, (m_ph != 0) ? 1 : 0);
    bus.sample_en = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.sample_en = 1'b0;
    repeat (n) @(posedge a_clk);
    #1;
  endtask

  always @(negedge a_clk) begin
    if (reset_n === 1'b1) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected out_valid: got 1 want 0 (cyc %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("audio_out", {16'h0, bus.audio_out}, {16'h0, e.audio});
          chk("latency", cyc, e.cyc + 2);
          m_last = e.audio;
        end
      end else begin
        chk("audio hold", {16'h0, bus.audio_out}, {16'h0, m_last});
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, " audio_out"}, {16'h0, bus.audio_out}, 0);
    chk({tag, " env_out"},   {16'h0, bus.env_out},   0);
    chk({tag, " out_valid"}, {31'h0, bus.out_valid}, 0);
    chk({tag, " busy"},      {31'h0, bus.busy},      0);
  endtask

  initial begin
    logic g;
    int   budget;
    // Strobe held during reset must be ignored.
    reset_n = 1'b0;
    bus.sample_en = 1'b1; bus.noise_in = 16'h7FFF; bus.vel = 4'd0; bus.gate = 1'b1;
    bus.attack_rate = 8'h00; bus.release_rate = 8'h00;
    repeat (3) @(posedge a_clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;
    idle(3);

    // Idle: no envelope, silent output.
    for (int i = 0; i < 3; i++) strobe(16'h4000, 4'd0, 1'b0, 8'h80, 8'h40);
    idle(3);

    // Attack in two steps, then gain points at sustain.
    strobe(16'h7FFF, 4'd0, 1'b1, 8'h80, 8'h40);
    strobe(16'h7FFF, 4'd0, 1'b1, 8'h80, 8'h40);
    strobe(16'h7FFF, 4'd0, 1'b1, 8'h80, 8'h40);
    strobe(16'h7FFF, 4'd8, 1'b1, 8'h80, 8'h40);
    idle(2);
    strobe(16'h7FFF, 4'd15, 1'b1, 8'h80, 8'h40);
    strobe(16'h8000, 4'd3, 1'b1, 8'h80, 8'h40);
    idle(2);

    // Release to zero in four steps.
    for (int i = 0; i < 4; i++) strobe(16'h8000, 4'd1, 1'b0, 8'h80, 8'h40);
    idle(2);

    // Retrigger mid-release.
    strobe(16'h1234, 4'd0, 1'b1, 8'h00, 8'h40);
    strobe(16'h1234, 4'd0, 1'b0, 8'h80, 8'h40);
    strobe(16'h1234, 4'd0, 1'b0, 8'h80, 8'h40);
    strobe(16'hC001, 4'd2, 1'b1, 8'h80, 8'h40);
    idle(3);

    // Randomized traffic with gaps and occasional instant rates.
    g = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] ar, rr;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) g = ~g;
      ar = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rr = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      strobe(16'($urandom), 4'($urandom_range(0, 15)), g, ar, rr);
    end
    idle(4);

    // Reset mid-attack with a sample in flight.
    strobe(16'h0000, 4'd0, 1'b0, 8'h10, 8'h00);
    strobe(16'h5555, 4'd1, 1'b1, 8'h10, 8'h00);
    idle(3);
    strobe(16'h5555, 4'd1, 1'b1, 8'h10, 8'h00);
    reset_n = 1'b0;
    bus.sample_en = 1'b1;
    void'(q.pop_back());
    m_env = 0; m_ph = 0;
    @(posedge a_clk); #1;
    chk_zero("midreset");
    m_last = 16'h0;
    reset_n = 1'b1;
    bus.sample_en = 1'b0;
    idle(5);

    budget = 20;
    while (q.size() != 0 && budget > 0) begin @(posedge a_clk); budget--; end
    #1;
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
